// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and result record for the ALU
// issue/capture stage and its result FIFO.
package alu_pkg;

  localparam int ALU_W  = 8;
  localparam int NFLAGS = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam int FLAG_PARITY   = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_GREATER  = 2;
  localparam int FLAG_LESS     = 3;
  localparam int FLAG_IS_EQ    = 4;

  typedef struct packed {
    logic [ALU_W-1:0]  y;
    logic [NFLAGS-1:0] flags;
  } result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO for captured ALU results; head is read straight from storage at
// the read pointer, so an empty/reset FIFO presents zeros.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          push_y_i,
  input  logic [NFLAGS-1:0]         push_flags_i,
  input  logic                      pop_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      head_valid_o,
  output logic [WIDTH-1:0]          head_y_o,
  output logic [NFLAGS-1:0]         head_flags_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0]  y_q [DEPTH];
  logic [NFLAGS-1:0] f_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       count_q;
  logic              do_pop;

  // A pop request against an empty FIFO is ignored rather than corrupting count.
  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        y_q[i] <= '0;
        f_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        y_q[wr_q] <= push_y_i;
        f_q[wr_q] <= push_flags_i;
        wr_q      <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (push_i && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push_i && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_y_o     = y_q[rd_q];
  assign head_flags_o = f_q[rd_q];

endmodule

// File: rtl/alu_issue_capture.sv
// Operand-issue / result-capture stage around the combinational ALU.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_issue_capture
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_parity,
  input  logic             alu_overflow,
  input  logic             alu_greater,
  input  logic             alu_less,
  input  logic             alu_is_eq,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [4:0]       rsp_flags
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic             clr_sticky,
  output logic             sticky_ovf
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e            state_q;
  logic [1:0]        alu_op_q;
  logic [WIDTH-1:0]  alu_a_q, alu_b_q;
  logic [CW-1:0]     count;
  logic              accept, push;
  logic [NFLAGS-1:0] flags;

  // Nothing is in flight while IDLE, so FIFO occupancy alone decides space.
  assign req_ready = rst_n && (state_q == IDLE) && (count < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = (state_q == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_op_q <= req_op;
            alu_a_q  <= req_a;
            alu_b_q  <= req_b;
            state_q  <= EXEC;
          end
        end
        EXEC:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;

  always_comb begin
    flags                = '0;
    flags[FLAG_PARITY]   = alu_parity;
    flags[FLAG_OVERFLOW] = alu_overflow;
    flags[FLAG_GREATER]  = alu_greater;
    flags[FLAG_LESS]     = alu_less;
    flags[FLAG_IS_EQ]    = alu_is_eq;
  end

  alu_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .push_i       (push),
    .push_y_i     (alu_y),
    .push_flags_i (flags),
    .pop_i        (rsp_ready),
    .count_o      (count),
    .head_valid_o (rsp_valid),
    .head_y_o     (rsp_y),
    .head_flags_o (rsp_flags)
  );

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q;

  // A capture with overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (push && alu_overflow) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_issue_capture.sv
// Randomised bench for alu_issue_capture with a queue-based reference model
// and a few hand-computed literal expectations.
module tb_alu_issue_capture;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [WIDTH-1:0] req_a = '0, req_b = '0;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             alu_parity, alu_overflow, alu_greater, alu_less, alu_is_eq;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_y;
  logic [4:0]       rsp_flags;
`ifdef ALU_STICKY_OVF_EN
  logic             clr_sticky = 1'b0;
  logic             sticky_ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit rnd_rsp = 1'b0;

  always #5 clk = ~clk;

  alu_issue_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_y        (alu_y),
    .alu_parity   (alu_parity),
    .alu_overflow (alu_overflow),
    .alu_greater  (alu_greater),
    .alu_less     (alu_less),
    .alu_is_eq    (alu_is_eq),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_flags    (rsp_flags)
`ifdef ALU_STICKY_OVF_EN
    ,
    .clr_sticky   (clr_sticky),
    .sticky_ovf   (sticky_ovf)
`endif
  );

  // Arithmetic definition of the 8-bit ALU.
  function automatic result_t alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    result_t r;
    logic    ovf;
    ovf = 1'b0;
    case (op)
      2'd0: begin r.y = a + b; ovf = (a[7] == b[7]) && (r.y[7] != a[7]); end
      2'd1: begin r.y = a - b; ovf = (a[7] != b[7]) && (r.y[7] != a[7]); end
      2'd2: r.y = a & b;
      default: r.y = a | b;
    endcase
    r.flags                = '0;
    r.flags[FLAG_PARITY]   = ^r.y;
    r.flags[FLAG_OVERFLOW] = ovf;
    r.flags[FLAG_GREATER]  = (a > b);
    r.flags[FLAG_LESS]     = (a < b);
    r.flags[FLAG_IS_EQ]    = (a == b);
    return r;
  endfunction

  result_t alu_r;
  assign alu_r        = alu_f(alu_op, alu_a, alu_b);
  assign alu_y        = alu_r.y;
  assign alu_parity   = alu_r.flags[FLAG_PARITY];
  assign alu_overflow = alu_r.flags[FLAG_OVERFLOW];
  assign alu_greater  = alu_r.flags[FLAG_GREATER];
  assign alu_less     = alu_r.flags[FLAG_LESS];
  assign alu_is_eq    = alu_r.flags[FLAG_IS_EQ];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: results queued in order, plus one op executing.
  result_t    pend[$];
  result_t    infl;
  bit         infl_v   = 1'b0;
  logic [1:0] m_op     = '0;
  logic [7:0] m_a      = '0, m_b = '0;
  bit         m_sticky = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      infl_v   = 1'b0;
      m_op     = '0;
      m_a      = '0;
      m_b      = '0;
      m_sticky = 1'b0;
    end else begin
      bit rdy;
      rdy = !infl_v && (pend.size() < DEPTH);
      if (pend.size() != 0 && rsp_ready) void'(pend.pop_front());
`ifdef ALU_STICKY_OVF_EN
      if (infl_v && infl.flags[FLAG_OVERFLOW]) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
`endif
      if (infl_v) begin
        pend.push_back(infl);
        infl_v = 1'b0;
      end else if (rdy && req_valid) begin
        infl   = alu_f(req_op, req_a, req_b);
        infl_v = 1'b1;
        m_op   = req_op;
        m_a    = req_a;
        m_b    = req_b;
      end
    end
  end

  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(rst_n && !infl_v && (pend.size() < DEPTH)));
    check("rsp_valid", 32'(rsp_valid), 32'(pend.size() != 0));
    if (pend.size() != 0) begin
      check("rsp_y", 32'(rsp_y), 32'(pend[0].y));
      check("rsp_flags", 32'(rsp_flags), 32'(pend[0].flags));
    end else if (!rst_n) begin
      check("rsp_y_rst", 32'(rsp_y), 32'd0);
      check("rsp_flags_rst", 32'(rsp_flags), 32'd0);
    end
    check("alu_op", 32'(alu_op), 32'(m_op));
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(m_b));
`ifdef ALU_STICKY_OVF_EN
    check("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
`endif
  end

  always @(posedge clk) begin
    if (rnd_rsp) begin
      #1;
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      if (req_ready) ok = 1'b1;
    end
    #1 req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: req_ready never seen, expected accept");
    end
  endtask

  task automatic drain();
    bit done;
    done      = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      if (pend.size() == 0 && !infl_v) done = 1'b1;
    end
    #1 rsp_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", pend.size());
    end
  endtask

  task automatic rand_op();
    issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    logic [7:0] last_a;

    repeat (2) @(posedge clk);
    #1;
    check("lit_rst_req_ready", 32'(req_ready), 32'd0);
    check("lit_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("lit_post_rst_req_ready", 32'(req_ready), 32'd1);

    // Single ADD with the 2-cycle result latency.
    issue(2'd0, 8'h05, 8'h03);
    check("lit_lat1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("lit_lat1_alu_a", 32'(alu_a), 32'h05);
    @(posedge clk); #1;
    check("lit_lat2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lit_add_y", 32'(rsp_y), 32'h08);
    check("lit_add_flags", 32'(rsp_flags), 32'b00101);
    drain();

    // Fill the FIFO with the consumer stalled; a fifth request must wait.
    for (int i = 0; i < 4; i++) begin
      last_a = 8'($urandom);
      issue(2'($urandom_range(0, 3)), last_a, 8'($urandom));
    end
    @(posedge clk); #1;
    check("lit_full_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_op    = 2'd3;
    req_a     = ~last_a;
    req_b     = 8'h11;
    repeat (4) begin
      @(posedge clk); #1;
      check("lit_full_hold_ready", 32'(req_ready), 32'd0);
      check("lit_full_hold_alu_a", 32'(alu_a), 32'(last_a));
    end
    req_valid = 1'b0;

    // Pop one to reach 3, then push and pop on the same edge.
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(2'd1, 8'h40, 8'h41);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("lit_pushpop_req_ready", 32'(req_ready), 32'd1);
    drain();

    // Pointer wrap with a randomly stalling consumer.
    rnd_rsp = 1'b1;
    for (int i = 0; i < 10; i++) rand_op();
    rnd_rsp = 1'b0;
    @(posedge clk); #2;
    drain();

    // Reset while executing with two results queued.
    rsp_ready = 1'b0;
    rand_op();
    rand_op();
    @(posedge clk); #1;
    rand_op();
    rst_n = 1'b0;
    #1;
    check("lit_mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("lit_mid_rst_rsp_y", 32'(rsp_y), 32'd0);
    check("lit_mid_rst_flags", 32'(rsp_flags), 32'd0);
    check("lit_mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("lit_mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("lit_mid_rst_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'd1, 8'h10, 8'h20);
    @(posedge clk); #1;
    check("lit_sub_y", 32'(rsp_y), 32'hF0);
    check("lit_sub_flags", 32'(rsp_flags), 32'b01000);
    drain();

`ifdef ALU_STICKY_OVF_EN
    rsp_ready = 1'b1;
    issue(2'd0, 8'h7F, 8'h01);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("lit_sticky_set", 32'(sticky_ovf), 32'd1);
    issue(2'd2, 8'h0F, 8'h03);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("lit_sticky_hold", 32'(sticky_ovf), 32'd1);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("lit_sticky_clr", 32'(sticky_ovf), 32'd0);
    issue(2'd0, 8'h7F, 8'h01);
    rsp_ready  = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("lit_sticky_set_wins", 32'(sticky_ovf), 32'd1);
    drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_capture.md
# alu_issue_capture

Operand-issue and result-capture stage that wraps the combinational 8-bit ALU datapath. It accepts operation requests over a valid/ready handshake and holds the operands and opcode stable on the ALU inputs for one full cycle. It then captures the ALU result and flags into a small result FIFO, which it drains to the downstream consumer over a second valid/ready handshake.

## Interface
- `WIDTH`, 8: operand/result width; matches the ALU datapath.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: stage accepts request this cycle.
- `req_op` in 2: opcode (`alu_pkg::op_e`).
- `req_a`, `req_b` in WIDTH: operands.
- `alu_op` out 2: registered opcode driven to ALU.
- `alu_a`, `alu_b` out WIDTH: registered operands driven to ALU.
- `alu_y` in WIDTH: ALU result.
- `alu_parity`, `alu_overflow`, `alu_greater`, `alu_less`, `alu_is_eq` in 1 each: ALU flags.
- `rsp_valid` out 1: FIFO head valid.
- `rsp_ready` in 1: consumer takes head.
- `rsp_y` out WIDTH: head result.
- `rsp_flags` out 5: head flags {is_eq, less, greater, overflow, parity}, bit 4 to bit 0.
- `clr_sticky` in 1: clears sticky overflow; present only with `ALU_STICKY_OVF_EN`.
- `sticky_ovf` out 1: present only with `ALU_STICKY_OVF_EN`.

## Operation
- FSM states are IDLE and EXEC. Reset state is IDLE.
- `req_ready` = (state==IDLE) && (count + inflight < DEPTH). In IDLE, inflight = 0.
- IDLE, on `req_valid && req_ready`: latch `req_op/a/b` into `alu_op/a/b` and go to EXEC.
- EXEC: ALU inputs are stable for the whole cycle. At the closing edge, push {`alu_y`, flags} into the FIFO and return to IDLE. The push always succeeds because space was reserved at accept.
- `alu_op/a/b` hold their last values in IDLE and are not cleared.
- FIFO: head outputs are driven directly from the storage array at the read pointer.
  - Pop on `rsp_valid && rsp_ready`.
  - `rsp_valid` = (count != 0).
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: both occur and count is unchanged. This includes push and pop at count==1 and at count==DEPTH-1.
- Pop while empty cannot occur because `rsp_valid` is 0. `rsp_ready` is ignored when empty.
- Flags and result are stored unmodified. The stage performs no arithmetic.
- `alu_pkg` opcode encoding: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
- Reset values: state IDLE, `req_ready` 0 while `rst_n` low and 1 after release, `alu_op/a/b` 0, `rsp_valid` 0, `rsp_y` 0, `rsp_flags` 0, pointers and count 0, `sticky_ovf` 0.
- Reset mid-operation: an in-flight EXEC op and all FIFO contents are discarded. No partial push occurs.

## Timing
- Request accepted at edge N.
  - `alu_*` are valid from N to N+1.
  - FIFO push occurs at N+1.
  - `rsp_valid` rises after N+1 if the FIFO was empty: 2-cycle latency.
- Throughput: one op per 2 cycles. `req_ready` is low during EXEC.
- `rsp_ready` has no combinational path to `req_ready`. `req_ready` depends on registered state and count only.
- A pop at edge N+1 frees a slot visible to `req_ready` after N+1.

## Configuration
- `ALU_STICKY_OVF_EN` defined:
  - A `sticky_ovf` register sets on any EXEC push with `alu_overflow`=1.
  - It clears on `clr_sticky`=1. Set wins over a simultaneous clear.
  - Ports `clr_sticky` and `sticky_ovf` exist.
- Undefined: the register and both ports are absent. Behaviour is otherwise identical.

## Structure
- `alu_pkg` holds `op_e` and its encodings, the FLAG_* bit indices (FLAG_PARITY=0 … FLAG_IS_EQ=4), and the `result_t` struct {y, flags}.
- One sub-module, `alu_result_fifo` (parameters WIDTH and DEPTH, push/pop/count/head), instantiated once.
- The FSM and operand registers live in the top.

## Test plan
- Reset then single op: ADD a=8'h05, b=8'h03, ALU model returns y=8'h08, parity=1, greater=1 -> `rsp_valid` is 1 exactly 2 cycles after accept, `rsp_y`=8'h08, `rsp_flags`=5'b00101.
- Back-to-back with `rsp_ready`=0: 4 requests -> `req_ready` deasserts after the 4th accept, count is 4, and a 5th request is held with no accept.
- Drain with `rsp_ready`=1 concurrent with issue at count 3: push and pop in the same cycle -> count stays 3 and results come out in order with no loss or duplication.
- Pointer wrap: 10 ops through DEPTH=4 with random `rsp_ready` -> all 10 results emerge in order, matching the ALU model.
- Assert `rst_n` low during EXEC with 2 entries queued -> `rsp_valid`=0 immediately and all outputs at reset values. The first op after release returns a correct result.
- With `ALU_STICKY_OVF_EN`: ADD 8'h7F+8'h01 (model overflow=1) -> `sticky_ovf` goes to 1 and stays high through later non-overflow ops. `clr_sticky` pulsed in the same cycle as an overflow push -> `sticky_ovf` remains 1.
